// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command scheduler: command codes, FSM states
// and the default pixel address width.
package lcd_pkg;

    localparam int CMD_W  = 3;
    localparam int AW_DEF = 6;

    localparam logic [CMD_W-1:0] CMD_WRITE = 3'd0;
    localparam logic [CMD_W-1:0] CMD_UP    = 3'd1;
    localparam logic [CMD_W-1:0] CMD_DOWN  = 3'd2;
    localparam logic [CMD_W-1:0] CMD_LEFT  = 3'd3;
    localparam logic [CMD_W-1:0] CMD_RIGHT = 3'd4;
    localparam logic [CMD_W-1:0] CMD_AVG   = 3'd5;
    localparam logic [CMD_W-1:0] CMD_MIRX  = 3'd6;
    localparam logic [CMD_W-1:0] CMD_MIRY  = 3'd7;

    typedef enum logic [2:0] {
        LOAD,
        DRAIN,
        RUN,
        ISSUE,
        WRITE,
        DONE
    } state_t;

    // Every code other than the write-back is forwarded to the datapath.
    function automatic logic is_op_cmd(input logic [CMD_W-1:0] cmd);
        return cmd != CMD_WRITE;
    endfunction

endpackage

// File: rtl/lcd_cmd_sched_if.sv
// Host command and datapath command handshakes of the LCD scheduler.
// master = host/datapath side, slave = scheduler side.
interface lcd_cmd_sched_if;
    import lcd_pkg::*;

    logic [CMD_W-1:0] host_cmd;
    logic             host_valid;
    logic             host_ready;
    logic [CMD_W-1:0] dp_cmd;
    logic             dp_cmd_valid;
    logic             dp_busy;

    modport master (
        output host_cmd, host_valid, dp_busy,
        input  host_ready, dp_cmd, dp_cmd_valid
    );

    modport slave (
        input  host_cmd, host_valid, dp_busy,
        output host_ready, dp_cmd, dp_cmd_valid
    );

endinterface

// File: rtl/lcd_cmd_fifo.sv
// Small synchronous command FIFO with occupancy count; pointers wrap modulo
// DEPTH (power of two), async active-low reset empties it.
module lcd_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an empty count makes its contents irrelevant.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/lcd_cmd_sched.sv
// Start-up IROM load sequencer plus host command scheduler for the 8x8 image
// datapath: op commands go out over valid/busy, command 0 runs IRB write-back.
module lcd_cmd_sched import lcd_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int AW    = AW_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    lcd_cmd_sched_if.slave         bus,
    output logic                   IROM_EN,
    output logic [AW-1:0]          IROM_A,
    output logic                   load_en,
    output logic [AW-1:0]          load_a,
    output logic                   IRB_RW,
    output logic [AW-1:0]          IRB_A,
    output logic [$clog2(DEPTH):0] q_count,
    output logic                   busy,
    output logic                   done
);

    localparam logic [AW-1:0] ADDR_LAST = {AW{1'b1}};

    state_t           state_q, state_d;
    logic [AW-1:0]    irom_a_q, irom_a_d;
    logic [AW-1:0]    irb_a_q, irb_a_d;
    logic             load_en_q, load_en_d;
    logic [AW-1:0]    load_a_q, load_a_d;
    logic [CMD_W-1:0] dp_cmd_q, dp_cmd_d;

    logic             fifo_pop;
    logic [CMD_W-1:0] fifo_head;
    logic             fifo_full;
    logic             fifo_empty;

    lcd_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (bus.host_valid),
        .din   (bus.host_cmd),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .count (q_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        irom_a_d  = irom_a_q;
        irb_a_d   = irb_a_q;
        dp_cmd_d  = dp_cmd_q;
        fifo_pop  = 1'b0;
        load_en_d = (state_q == LOAD);
        load_a_d  = irom_a_q;

        case (state_q)
            LOAD: begin
                irom_a_d = irom_a_q + 1'b1;
                if (irom_a_q == ADDR_LAST) state_d = DRAIN;
            end
            // One idle cycle lets the last ROM word land in the buffer.
            DRAIN: state_d = RUN;
            RUN: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (is_op_cmd(fifo_head)) begin
                        dp_cmd_d = fifo_head;
                        state_d  = ISSUE;
                    end else begin
                        irb_a_d = '0;
                        state_d = WRITE;
                    end
                end
            end
            ISSUE: begin
                if (!bus.dp_busy) state_d = RUN;
            end
            WRITE: begin
                irb_a_d = irb_a_q + 1'b1;
                if (irb_a_q == ADDR_LAST) state_d = DONE;
            end
            DONE:    state_d = RUN;
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= LOAD;
            irom_a_q  <= '0;
            irb_a_q   <= '0;
            load_en_q <= 1'b0;
            load_a_q  <= '0;
            dp_cmd_q  <= '0;
        end else begin
            state_q   <= state_d;
            irom_a_q  <= irom_a_d;
            irb_a_q   <= irb_a_d;
            load_en_q <= load_en_d;
            load_a_q  <= load_a_d;
            dp_cmd_q  <= dp_cmd_d;
        end
    end

    // Reset is folded in so the ROM stays disabled while reset is held in LOAD.
    assign IROM_EN          = !reset || (state_q != LOAD);
    assign IROM_A           = irom_a_q;
    assign load_en          = load_en_q;
    assign load_a           = load_a_q;
    assign IRB_RW           = (state_q != WRITE);
    assign IRB_A            = irb_a_q;
    assign busy             = (state_q != RUN);
    assign done             = (state_q == DONE);
    assign bus.dp_cmd       = dp_cmd_q;
    assign bus.dp_cmd_valid = (state_q == ISSUE);
    assign bus.host_ready   = reset && !fifo_full;

endmodule
